psx_poll_master: RTL and testbench

//  Console-side master for the PSX controller serial link. Drives att, psx_clk and cmd,
//  and receives data and ack from a controller such as fake_controller. Each start

---
 rtl/psx_poll_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_psx_poll_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/psx_poll_master.sv
// PSX controller link master: runs one 5-byte poll frame per start pulse
// and returns the controller ID and button bits.
module psx_poll_master #(
  parameter int CLK_DIV     = 4,
  parameter int ATT_SETUP   = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int BYTE_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        data,
  input  logic        ack,
  output logic        psx_clk,
  output logic        cmd,
  output logic        att,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  id,
  output logic [15:0] buttons,
  output logic        timeout_err,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_ACKW, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0] DIV_L = 16'(CLK_DIV - 1);
  localparam logic [15:0] SET_L = 16'(ATT_SETUP - 1);
  localparam logic [15:0] TO_L  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_L = 16'(BYTE_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        hi_q, hi_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  b1_q, b1_d, b2_q, b2_d;
  logic [7:0]  b3_q, b3_d, b4_q, b4_d;
  logic        seen_q, seen_d;
  logic        sclk_q, sclk_d;
  logic        cmd_q, cmd_d;
  logic        att_q, att_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  id_q, id_d;
  logic [15:0] btn_q, btn_d;
  logic        terr_q, terr_d;
  logic        ferr_q, ferr_d;
  logic [1:0]  dsync_q, async_q;

  logic       rx_bit, ack_low;
  logic [7:0] rx_full, tx_cur, tx_nxt;
  logic [15:0] cnt_inc;

  function automatic logic [7:0] tx_byte(input logic [2:0] i);
    logic [7:0] b;
    unique case (i)
      3'd0:    b = 8'h01;
      3'd1:    b = 8'h42;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign rx_bit  = dsync_q[1];
  assign ack_low = ~async_q[1];
  assign rx_full = {rx_bit, rx_q[7:1]};
  assign tx_cur  = tx_byte(idx_q);
  assign tx_nxt  = tx_byte(idx_q + 3'd1);
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b1;
      idx_q   <= '0;
      rx_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      b3_q    <= '0;
      b4_q    <= '0;
      seen_q  <= 1'b0;
      sclk_q  <= 1'b1;
      cmd_q   <= 1'b1;
      att_q   <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= 8'hFF;
      btn_q   <= 16'hFFFF;
      terr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dsync_q <= 2'b11;
      async_q <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      rx_q    <= rx_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      b4_q    <= b4_d;
      seen_q  <= seen_d;
      sclk_q  <= sclk_d;
      cmd_q   <= cmd_d;
      att_q   <= att_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      btn_q   <= btn_d;
      terr_q  <= terr_d;
      ferr_q  <= ferr_d;
      dsync_q <= {dsync_q[0], data};
      async_q <= {async_q[0], ack};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    bit_d   = bit_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    rx_d    = rx_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    b4_d    = b4_q;
    seen_d  = seen_q | ack_low;
    sclk_d  = sclk_q;
    cmd_d   = cmd_q;
    att_d   = att_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    id_d    = id_q;
    btn_d   = btn_q;
    terr_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          att_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SET_L) begin
          sclk_d  = 1'b0;
          cmd_d   = tx_cur[0];
          bit_d   = '0;
          hi_d    = 1'b0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_L) begin
          cnt_d = '0;
          if (!hi_q) begin
            sclk_d = 1'b1;
            rx_d   = rx_full;
            hi_d   = 1'b1;
            if (bit_q == 3'd7) begin
              unique case (idx_q)
                3'd1:    b1_d = rx_full;
                3'd2:    b2_d = rx_full;
                3'd3:    b3_d = rx_full;
                3'd4:    b4_d = rx_full;
                default: ;
              endcase
              state_d = (idx_q < 3'd4) ? S_ACKW : S_DONE;
            end
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 3'd1;
            cmd_d  = tx_cur[bit_q + 3'd1];
            hi_d   = 1'b0;
          end
        end
      end
      S_ACKW: begin
        // sticky flag also covers an ack that ended before this state
        if (seen_q || ack_low) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == TO_L) begin
          att_d   = 1'b1;
          busy_d  = 1'b0;
          cmd_d   = 1'b1;
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_L) begin
          idx_d   = idx_q + 3'd1;
          sclk_d  = 1'b0;
          cmd_d   = tx_nxt[0];
          bit_d   = '0;
          hi_d    = 1'b0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        att_d   = 1'b1;
        busy_d  = 1'b0;
        cmd_d   = 1'b1;
        state_d = S_IDLE;
        if (b2_q == 8'h5A) begin
          id_d    = b1_q;
          btn_d   = {b4_q, b3_q};
          valid_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign psx_clk     = sclk_q;
  assign cmd         = cmd_q;
  assign att         = att_q;
  assign busy        = busy_q;
  assign valid       = valid_q;
  assign id          = id_q;
  assign buttons     = btn_q;
  assign timeout_err = terr_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_psx_poll_master.sv
// Bench for psx_poll_master: behavioural pad model, frame vector table,
// and directed timeout / reset / start-collision sequences.
module tb_psx_poll_master;

  localparam int CLK_DIV     = 4;
  localparam int ATT_SETUP   = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int BYTE_GAP    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        data = 1'b1;
  logic        ack = 1'b1;
  logic        psx_clk, cmd, att, busy, valid;
  logic [7:0]  id;
  logic [15:0] buttons;
  logic        timeout_err, frame_err;

  always #5 clk = ~clk;

  psx_poll_master #(
    .CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP),
    .ACK_TIMEOUT(ACK_TIMEOUT), .BYTE_GAP(BYTE_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .data(data), .ack(ack),
    .psx_clk(psx_clk), .cmd(cmd), .att(att),
    .busy(busy), .valid(valid), .id(id),
    .buttons(buttons), .timeout_err(timeout_err),
    .frame_err(frame_err)
  );

  // pad model: byte n bit k driven after each psx_clk fall, ack after bytes 0-3
  logic [7:0] m_bytes [0:4];
  logic       m_ack_en = 1'b1;
  int         m_bit = 0, m_byte = 0, m_dly = 0, m_len = 0;
  logic       m_prev = 1'b1;

  always @(negedge clk) begin
    if (att) begin
      m_bit = 0; m_byte = 0; m_dly = 0; m_len = 0;
      data = 1'b1; ack = 1'b1;
    end else begin
      if (m_prev && !psx_clk && m_byte < 5)
        data = m_bytes[m_byte][m_bit];
      if (!m_prev && psx_clk) begin
        m_bit++;
        if (m_bit == 8) begin
          m_bit = 0;
          if (m_byte < 4 && m_ack_en) m_dly = 2;
          m_byte++;
        end
      end
      if (m_len > 0) begin
        m_len--;
        if (m_len == 0) ack = 1'b1;
      end
      if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin ack = 1'b0; m_len = 2; end
      end
    end
    m_prev = psx_clk;
  end

  int   cyc = 0;
  int   n_valid = 0, n_ferr = 0, n_terr = 0, n_rise = 0, n_attbad = 0;
  int   terr_cyc = 0, rise_cyc = 0;
  logic mon_prev = 1'b1;
  logic cmd_log [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (frame_err) n_ferr++;
    if (timeout_err) begin n_terr++; terr_cyc = cyc; end
    if (busy && att) n_attbad++;
    if (!mon_prev && psx_clk) begin
      if (n_rise < 4096) cmd_log[n_rise] = cmd;
      n_rise++;
      rise_cyc = cyc;
    end
    mon_prev = psx_clk;
  end

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_pad(input logic en, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] b4);
    m_ack_en   = en;
    m_bytes[0] = 8'hFF;
    m_bytes[1] = b1;
    m_bytes[2] = b2;
    m_bytes[3] = b3;
    m_bytes[4] = b4;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while (busy && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (busy) chk({nm, "_busy_stuck"}, 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input string nm);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle(nm);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic        ack_en;
    logic [7:0]  b1, b2, b3, b4;
    int          e_valid, e_ferr, e_terr, e_rise;
    logic [7:0]  e_id;
    logic [15:0] e_btn;
  } vec_t;

  vec_t vt [6];
  localparam logic [39:0] CMD_EXP = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};

  initial begin
    int v0, f0, t0, r0, a0;
    logic [39:0] bits;

    vt[0] = '{1'b1, 8'h41, 8'h5A, 8'hFE, 8'hFD, 1, 0, 0, 40, 8'h41, 16'hFDFE};
    vt[1] = '{1'b1, 8'h73, 8'h5A, 8'h34, 8'h12, 1, 0, 0, 40, 8'h73, 16'h1234};
    vt[2] = '{1'b1, 8'h41, 8'h00, 8'hAA, 8'h55, 0, 1, 0, 40, 8'h73, 16'h1234};
    vt[3] = '{1'b0, 8'h41, 8'h5A, 8'h00, 8'h00, 0, 0, 1, 8,  8'h73, 16'h1234};
    vt[4] = '{1'b1, 8'h82, 8'h5A, 8'h00, 8'hFF, 1, 0, 0, 40, 8'h82, 16'hFF00};
    vt[5] = '{1'b1, 8'h41, 8'hA5, 8'h00, 8'h00, 0, 1, 0, 40, 8'h82, 16'hFF00};

    set_pad(1'b1, 8'h41, 8'h5A, 8'hFE, 8'hFD);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state",
        64'({psx_clk, cmd, att, busy, valid, timeout_err, frame_err,
             id, buttons}),
        64'({7'b1110000, 8'hFF, 16'hFFFF}));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ack never arrives: timeout after byte 0
    set_pad(1'b0, 8'h41, 8'h5A, 8'hFE, 8'hFD);
    v0 = n_valid; t0 = n_terr; r0 = n_rise;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle("timeout");
    @(negedge clk);
    chk("to_pulses", 64'(n_terr - t0), 64'd1);
    chk("to_latency", 64'(terr_cyc - rise_cyc), 64'(ACK_TIMEOUT));
    chk("to_rises", 64'(n_rise - r0), 64'd8);
    chk("to_att_busy", 64'({att, busy}), 64'(2'b10));
    chk("to_outputs", 64'({id, buttons}), 64'({8'hFF, 16'hFFFF}));
    chk("to_novalid", 64'(n_valid - v0), 64'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      set_pad(vt[i].ack_en, vt[i].b1, vt[i].b2, vt[i].b3, vt[i].b4);
      v0 = n_valid; f0 = n_ferr; t0 = n_terr; r0 = n_rise; a0 = n_attbad;
      run_frame($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_valid", i), 64'(n_valid - v0), 64'(vt[i].e_valid));
      chk($sformatf("vec%0d_ferr", i), 64'(n_ferr - f0), 64'(vt[i].e_ferr));
      chk($sformatf("vec%0d_terr", i), 64'(n_terr - t0), 64'(vt[i].e_terr));
      chk($sformatf("vec%0d_rises", i), 64'(n_rise - r0), 64'(vt[i].e_rise));
      chk($sformatf("vec%0d_id", i), 64'(id), 64'(vt[i].e_id));
      chk($sformatf("vec%0d_btn", i), 64'(buttons), 64'(vt[i].e_btn));
      chk($sformatf("vec%0d_att", i), 64'(n_attbad - a0), 64'd0);
      if (vt[i].e_rise == 40) begin
        for (int k = 0; k < 40; k++) bits[k] = cmd_log[r0 + k];
        chk($sformatf("vec%0d_cmd", i), 64'(bits), 64'(CMD_EXP));
      end
    end

    // reset in the middle of byte 2, then a clean frame
    set_pad(1'b1, 8'h41, 8'h5A, 8'hFE, 8'hFD);
    v0 = n_valid; r0 = n_rise;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 2000 && (n_rise - r0) < 20; i++) @(negedge clk);
    chk("mid_reached", 64'(n_rise - r0 >= 20), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pins", 64'({att, psx_clk, cmd, busy}), 64'(4'b1110));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_novalid", 64'(n_valid - v0), 64'd0);
    v0 = n_valid;
    run_frame("after_rst");
    chk("after_rst_valid", 64'(n_valid - v0), 64'd1);
    chk("after_rst_data", 64'({id, buttons}), 64'({8'h41, 16'hFDFE}));

    // start held through the whole frame including the DONE cycle
    set_pad(1'b1, 8'h55, 8'h5A, 8'h0F, 8'hF0);
    v0 = n_valid; r0 = n_rise;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("spam_valid", 64'(n_valid - v0), 64'd1);
    chk("spam_rises", 64'(n_rise - r0), 64'd40);
    chk("spam_idle", 64'({busy, att}), 64'(2'b01));
    chk("spam_data", 64'({id, buttons}), 64'({8'h55, 16'hF00F}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
